mem_stage_mc: RTL and testbench
===============================

# mem_stage_mc

Parametrised multi-cycle successor to the pipeline's MEM stage. Decodes the instruction in MEM, resolves forwarded store data, and accesses an internal word-organised data memory with byte/halfword/word granularity. A programmable access latency is enforced by a small FSM that stalls the pipeline. Misaligned and out-of-range accesses are flagged instead of corrupting memory. Sits between the EX/MEM and MEM/WB pipeline registers.

## Interface
- DEPTH_WORDS, 4096: data memory depth in 32-bit words; power of two.
- LATENCY, 1: extra cycles per load/store, 0..7; 0 gives single-cycle behaviour.
- BASE_ADDR, 32'h0000_0000: byte address of word 0.

- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- valid_M  in  1  instruction in MEM is valid; 0 behaves as nop.
- ForwardRTM  in  2  store-data select: 00 WriteData_M, 01 result_W, 10 result_WD, 11 WriteData_M.
- result_W, result_WD  in  32 each  forwarding sources from WB.
- instr_M  in  32  instruction in MEM.
- ALUout_M  in  32  effective byte address.
- WriteData_M  in  32  rt value from EX/MEM.
- PC_M  in  32  PC of the instruction; used only in the store trace.
- RegWrite_M  out  1  the instruction writes the GPR file.
- Mem2Reg_M  out  2  WB source: 00 ALU, 01 memory, 10 PC+8.
- ReadData_M  out  32  extended load data.
- stall_M  out  1  freeze PC, IF/ID, ID/EX and EX/MEM; bubble into MEM/WB.
- addr_exc_M  out  1  misaligned or out-of-range memory access.

## Operation
- Memory opcodes:
  - lw 100011, sw 101011.
  - lb 100000, lbu 100100, lh 100001, lhu 100101, sb 101000, sh 101001.
- RegWrite_M is 1 for:
  - R-type except jr (funct 001000);
  - opcodes 001xxx;
  - loads;
  - jal 000011.
- Mem2Reg_M:
  - 01 for loads;
  - 10 for jal and for jalr (R-type, funct 001001);
  - 00 otherwise.
- These decode outputs are combinational. They are forced to 0 when valid_M=0.
- Word index = (ALUout_M - BASE_ADDR)[31:2].
- addr_exc_M=1 when any of the following holds:
  - word/halfword access is not aligned to its size;
  - address < BASE_ADDR;
  - index >= DEPTH_WORDS.
- On an exception: no write, no stall, ReadData_M=0, and RegWrite_M is forced to 0.
- Store data = ForwardRTM mux output.
  - sb writes lane addr[1:0] from bits [7:0].
  - sh writes lane addr[1] from bits [15:0].
  - sw writes the whole word.
  - Other lanes are preserved.
- Loads select the lane by the same rule. lb/lh sign-extend; lbu/lhu zero-extend.
- FSM states: IDLE, WAIT.
  - IDLE -> WAIT on a valid, non-excepting memory op with LATENCY>0. Load cnt=LATENCY-1 on the transition.
  - WAIT decrements cnt each cycle and returns to IDLE after the cycle in which cnt=0.
  - stall_M = (IDLE and entering WAIT) or (WAIT and cnt!=0).
  - The commit cycle is the first cycle with stall_M=0. The store is written on that cycle's rising edge, and ReadData_M is valid during it.
- Non-memory instructions never stall.
- While stalled, inputs must be held stable. Changes are ignored, except ForwardRTM/result_W/result_WD, which are sampled in the commit cycle.

## Timing
- Reset values:
  - state=IDLE, cnt=0, stall_M=0, addr_exc_M=0;
  - all memory words cleared to 0 on the reset edge;
  - RegWrite_M=0, Mem2Reg_M=00, ReadData_M=0 while reset is held.
- Total memory op latency is LATENCY+1 cycles; stall_M is high for exactly LATENCY of them.
- Back-to-back memory ops: the second op enters IDLE->WAIT on the cycle after the first commits; there are no dead cycles.
- Reset asserted during WAIT aborts the access: no write, and stall_M=0 in the next cycle.
- Load-after-store to the same address in consecutive instructions returns the stored data, because the write commits before the next access is evaluated.

## Configuration
- MEM_SUBWORD_EN defined: all eight memory opcodes are supported as above.
- MEM_SUBWORD_EN undefined: only lw/sw are memory ops.
  - lb/lbu/lh/lhu/sb/sh decode as nops: RegWrite_M=0, no write, no stall.
  - Lane logic is removed, and any addr[1:0]!=0 on lw/sw raises addr_exc_M.

## Test plan
- LATENCY=2: sw to 0x10 with data 0xDEADBEEF -> stall_M high 2 cycles; write on the 3rd edge; a following lw 0x10 gives ReadData_M=0xDEADBEEF.
- sb 0x80 to addr 0x13, then lb and lbu from 0x13 -> word becomes 0x80000000; lb=0xFFFFFF80, lbu=0x00000080.
- ForwardRTM=01 with result_W=0x12345678 on sh to 0x22 -> word 0x20 upper half = 0x5678, lower half preserved.
- lw to 0x06, and sw to byte DEPTH_WORDS*4 -> addr_exc_M=1, no stall, memory unchanged, RegWrite_M=0.
- Reset pulsed in the first WAIT cycle of sw 0x40 = 0x1 -> stall_M=0 the next cycle; a later lw 0x40 reads 0.
- With MEM_SUBWORD_EN undefined: sb to 0x4 -> no write, RegWrite_M=0, stall_M stays 0.

Source files
------------

// File: rtl/mem_stage_mc_if.sv
// mem_stage_mc_if: bus between the EX/MEM register, the WB forwarding network and the
// multi-cycle MEM stage.
//   master modport: pipeline side; drives instruction, address, store data and
//                   forwarding sources, and receives the decode, load data, stall
//                   and exception outputs.
//   slave modport:  the MEM stage itself.
// Signal names follow the pipeline's existing _M/_W naming so they line up with the
// surrounding stage registers.
interface mem_stage_mc_if;
  logic        valid_M;
  logic [1:0]  ForwardRTM;
  logic [31:0] result_W;
  logic [31:0] result_WD;
  logic [31:0] instr_M;
  logic [31:0] ALUout_M;
  logic [31:0] WriteData_M;
  logic [31:0] PC_M;
  logic        RegWrite_M;
  logic [1:0]  Mem2Reg_M;
  logic [31:0] ReadData_M;
  logic        stall_M;
  logic        addr_exc_M;

  modport master (
    output valid_M, ForwardRTM, result_W, result_WD, instr_M, ALUout_M, WriteData_M, PC_M,
    input  RegWrite_M, Mem2Reg_M, ReadData_M, stall_M, addr_exc_M
  );

  modport slave (
    input  valid_M, ForwardRTM, result_W, result_WD, instr_M, ALUout_M, WriteData_M, PC_M,
    output RegWrite_M, Mem2Reg_M, ReadData_M, stall_M, addr_exc_M
  );
endinterface

// File: rtl/mem_stage_mc.sv
// mem_stage_mc: multi-cycle MEM stage with an internal word-organised data memory.
//   clk     rising-edge clock
//   reset   synchronous, active-high; also clears the whole data memory
//   mem_io  slave side of mem_stage_mc_if:
//     in : valid_M, ForwardRTM, result_W, result_WD, instr_M, ALUout_M, WriteData_M, PC_M
//     out: RegWrite_M, Mem2Reg_M, ReadData_M, stall_M, addr_exc_M
// Every load/store takes LATENCY+1 cycles; stall_M is high for the first LATENCY of
// them and the access commits on the first non-stalled cycle.
// Optional feature macro: MEM_SUBWORD_EN adds lb/lbu/lh/lhu/sb/sh with byte-lane logic.
// Without it only lw/sw are memory ops and any low address bit set on them is an
// address exception.
module mem_stage_mc #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY     = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic           clk,
  input logic           reset,
  mem_stage_mc_if.slave mem_io
);

  localparam int unsigned IdxW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic        HasLat  = (LATENCY > 0);
  localparam logic [2:0]  LatLoad = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] FnJr    = 6'b001000;
  localparam logic [5:0] FnJalr  = 6'b001001;
`ifdef MEM_SUBWORD_EN
  localparam logic [5:0] OpLb    = 6'b100000;
  localparam logic [5:0] OpLbu   = 6'b100100;
  localparam logic [5:0] OpLh    = 6'b100001;
  localparam logic [5:0] OpLhu   = 6'b100101;
  localparam logic [5:0] OpSb    = 6'b101000;
  localparam logic [5:0] OpSh    = 6'b101001;
`endif

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        stall_raw;

  logic [5:0]  opcode, funct;
  logic        is_rtype, is_load, is_store, mem_op;
  logic [31:0] addr, offset;
  logic        below_base, out_range, misalign, addr_exc;
  logic        mem_go, commit, we;
  logic [IdxW-1:0] idx;
  logic [31:0] store_data, rword, wword, load_data;

  logic [31:0] mem_q [DEPTH_WORDS];

  // Instruction bits outside opcode/funct and the trace-only PC are not needed here.
  logic unused_bits;
  assign unused_bits = ^{mem_io.instr_M[25:6], mem_io.PC_M};

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  assign opcode   = mem_io.instr_M[31:26];
  assign funct    = mem_io.instr_M[5:0];
  assign is_rtype = (opcode == OpRtype);

`ifdef MEM_SUBWORD_EN
  assign is_load  = (opcode == OpLw) || (opcode == OpLb) || (opcode == OpLbu) ||
                    (opcode == OpLh) || (opcode == OpLhu);
  assign is_store = (opcode == OpSw) || (opcode == OpSb) || (opcode == OpSh);
`else
  assign is_load  = (opcode == OpLw);
  assign is_store = (opcode == OpSw);
`endif

  assign mem_op = mem_io.valid_M && (is_load || is_store);

  // ---------------------------------------------------------------------------
  // Address checks
  // ---------------------------------------------------------------------------
  assign addr       = mem_io.ALUout_M;
  assign offset     = addr - BASE_ADDR;
  assign below_base = (addr < BASE_ADDR);
  assign out_range  = ({2'b00, offset[31:2]} >= 32'(DEPTH_WORDS));
  assign idx        = offset[IdxW+1:2];

`ifdef MEM_SUBWORD_EN
  always_comb begin
    misalign = 1'b0;
    if ((opcode == OpLw) || (opcode == OpSw)) begin
      misalign = (addr[1:0] != 2'b00);
    end else if ((opcode == OpLh) || (opcode == OpLhu) || (opcode == OpSh)) begin
      misalign = addr[0];
    end
  end
`else
  assign misalign = (addr[1:0] != 2'b00);
`endif

  assign addr_exc = mem_op && (misalign || below_base || out_range) && !reset;
  assign mem_go   = mem_op && !addr_exc;

  // ---------------------------------------------------------------------------
  // Latency FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_raw = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_go && HasLat) begin
          state_d   = StWait;
          cnt_d     = LatLoad;
          stall_raw = 1'b1;
        end
      end
      StWait: begin
        if (cnt_q != 3'd0) begin
          cnt_d     = cnt_q - 3'd1;
          stall_raw = 1'b1;
        end else begin
          // This is the commit cycle; the pipeline advances at its end.
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign commit = mem_go && !stall_raw && !reset;
  assign we     = commit && is_store;

  // ---------------------------------------------------------------------------
  // Store data forwarding; evaluated in the commit cycle so late WB results land
  // ---------------------------------------------------------------------------
  always_comb begin
    unique case (mem_io.ForwardRTM)
      2'b01:   store_data = mem_io.result_W;
      2'b10:   store_data = mem_io.result_WD;
      default: store_data = mem_io.WriteData_M;
    endcase
  end

  assign rword = mem_q[idx];

  // ---------------------------------------------------------------------------
  // Lane merge / extract
  // ---------------------------------------------------------------------------
`ifdef MEM_SUBWORD_EN
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    wword = rword;
    if (opcode == OpSw) begin
      wword = store_data;
    end else if (opcode == OpSh) begin
      if (addr[1]) wword[31:16] = store_data[15:0];
      else         wword[15:0]  = store_data[15:0];
    end else if (opcode == OpSb) begin
      unique case (addr[1:0])
        2'd0:    wword[7:0]   = store_data[7:0];
        2'd1:    wword[15:8]  = store_data[7:0];
        2'd2:    wword[23:16] = store_data[7:0];
        default: wword[31:24] = store_data[7:0];
      endcase
    end
  end

  always_comb begin
    unique case (addr[1:0])
      2'd0:    ld_byte = rword[7:0];
      2'd1:    ld_byte = rword[15:8];
      2'd2:    ld_byte = rword[23:16];
      default: ld_byte = rword[31:24];
    endcase
    ld_half = addr[1] ? rword[31:16] : rword[15:0];
    unique case (opcode)
      OpLb:    load_data = {{24{ld_byte[7]}}, ld_byte};
      OpLbu:   load_data = {24'd0, ld_byte};
      OpLh:    load_data = {{16{ld_half[15]}}, ld_half};
      OpLhu:   load_data = {16'd0, ld_half};
      default: load_data = rword;
    endcase
  end
`else
  assign wword     = store_data;
  assign load_data = rword;
`endif

  // ---------------------------------------------------------------------------
  // Data memory; reset clears every word
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else if (we) begin
      mem_q[idx] <= wword;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_io.RegWrite_M = 1'b0;
    mem_io.Mem2Reg_M  = 2'b00;
    mem_io.ReadData_M = 32'd0;
    if (mem_io.valid_M && !reset) begin
      mem_io.RegWrite_M = ((is_rtype && (funct != FnJr)) || (opcode[5:3] == 3'b001) ||
                           is_load || (opcode == OpJal)) && !addr_exc;
      if (is_load) begin
        mem_io.Mem2Reg_M = 2'b01;
      end else if ((opcode == OpJal) || (is_rtype && (funct == FnJalr))) begin
        mem_io.Mem2Reg_M = 2'b10;
      end
      if (mem_go && is_load) begin
        mem_io.ReadData_M = load_data;
      end
    end
  end

  assign mem_io.stall_M    = stall_raw && !reset;
  assign mem_io.addr_exc_M = addr_exc;

endmodule

// File: tb/tb_mem_stage_mc.sv
// Directed bench for mem_stage_mc with DEPTH_WORDS=64, LATENCY=2, BASE_ADDR=0.
// Subword cases are compiled only when MEM_SUBWORD_EN is defined; otherwise the
// subword opcodes are checked to behave as nops.
module tb_mem_stage_mc;

  localparam int unsigned Depth = 64;
  localparam int unsigned Lat   = 2;

  localparam logic [31:0] ILw   = 32'h8C00_0000;
  localparam logic [31:0] ISw   = 32'hAC00_0000;
  localparam logic [31:0] ILb   = 32'h8000_0000;
  localparam logic [31:0] ISb   = 32'hA000_0000;
  localparam logic [31:0] IAddi = 32'h2000_0000;
  localparam logic [31:0] IJal  = 32'h0C00_0000;
  localparam logic [31:0] IJr   = 32'h0000_0008;
  localparam logic [31:0] IJalr = 32'h0000_0009;
  localparam logic [31:0] IAdd  = 32'h0000_0020;
`ifdef MEM_SUBWORD_EN
  localparam logic [31:0] ILbu  = 32'h9000_0000;
  localparam logic [31:0] ILh   = 32'h8400_0000;
  localparam logic [31:0] ILhu  = 32'h9400_0000;
  localparam logic [31:0] ISh   = 32'hA400_0000;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  int          op_stalls;
  logic [31:0] op_rd;
  logic        op_rw;
  logic [1:0]  op_m2r;
  logic        op_exc;

  mem_stage_mc_if bus_if ();

  mem_stage_mc #(
    .DEPTH_WORDS (Depth),
    .LATENCY     (Lat),
    .BASE_ADDR   (32'h0000_0000)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .mem_io (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Present one instruction just after a rising edge, count stall cycles, capture
  // outputs in the first non-stalled cycle, then step past its commit edge.
  task automatic run_op(input logic v, input logic [31:0] ins, input logic [31:0] a,
                        input logic [31:0] wd);
    bit done;
    bus_if.valid_M     = v;
    bus_if.instr_M     = ins;
    bus_if.ALUout_M    = a;
    bus_if.WriteData_M = wd;
    bus_if.PC_M        = 32'h0040_0000;
    op_stalls = 0;
    done      = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (!bus_if.stall_M) begin
        op_rd  = bus_if.ReadData_M;
        op_rw  = bus_if.RegWrite_M;
        op_m2r = bus_if.Mem2Reg_M;
        op_exc = bus_if.addr_exc_M;
        done   = 1'b1;
      end else begin
        op_stalls++;
        if (op_stalls > 16) begin
          checks++;
          failures++;
          $display("FAIL stall_timeout: got=%0d stall cycles expected=%0d", op_stalls, Lat);
          done = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    bus_if.valid_M = 1'b0;
  endtask

  task automatic load_expect(input string tag, input logic [31:0] ins, input logic [31:0] a,
                             input logic [31:0] exp);
    run_op(1'b1, ins, a, 32'd0);
    check_eq(tag, op_rd, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus_if.valid_M     = 1'b1;
    bus_if.ForwardRTM  = 2'b00;
    bus_if.result_W    = 32'd0;
    bus_if.result_WD   = 32'd0;
    bus_if.instr_M     = ILw;
    bus_if.ALUout_M    = 32'h10;
    bus_if.WriteData_M = 32'd0;
    bus_if.PC_M        = 32'd0;

    // Outputs while reset is held, with a valid lw presented.
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_regwrite", 32'(bus_if.RegWrite_M), 32'd0);
    check_eq("rst_mem2reg",  32'(bus_if.Mem2Reg_M),  32'd0);
    check_eq("rst_readdata", bus_if.ReadData_M,      32'd0);
    check_eq("rst_stall",    32'(bus_if.stall_M),    32'd0);
    check_eq("rst_exc",      32'(bus_if.addr_exc_M), 32'd0);
    @(posedge clk);
    #1;
    reset          = 1'b0;
    bus_if.valid_M = 1'b0;
    @(posedge clk);
    #1;

    // Store then load at 0x10, back to back.
    run_op(1'b1, ISw, 32'h10, 32'hDEAD_BEEF);
    check_eq("sw_stalls", 32'(op_stalls), 32'd2);
    check_eq("sw_exc",    32'(op_exc),    32'd0);
    check_eq("sw_regwr",  32'(op_rw),     32'd0);
    run_op(1'b1, ILw, 32'h10, 32'd0);
    check_eq("lw_stalls", 32'(op_stalls), 32'd2);
    check_eq("lw_data",   op_rd,          32'hDEAD_BEEF);
    check_eq("lw_regwr",  32'(op_rw),     32'd1);
    check_eq("lw_m2r",    32'(op_m2r),    32'd1);

    // Store-data forwarding selects.
    bus_if.result_W  = 32'h1234_5678;
    bus_if.result_WD = 32'h0BAD_F00D;
    bus_if.ForwardRTM = 2'b01;
    run_op(1'b1, ISw, 32'h20, 32'hAAAA_AAAA);
    bus_if.ForwardRTM = 2'b10;
    run_op(1'b1, ISw, 32'h24, 32'hAAAA_AAAA);
    bus_if.ForwardRTM = 2'b11;
    run_op(1'b1, ISw, 32'h28, 32'hAAAA_AAAA);
    bus_if.ForwardRTM = 2'b00;
    load_expect("fwd_w",   ILw, 32'h20, 32'h1234_5678);
    load_expect("fwd_wd",  ILw, 32'h24, 32'h0BAD_F00D);
    load_expect("fwd_11",  ILw, 32'h28, 32'hAAAA_AAAA);

    // Address exceptions: no stall, no write, no register write.
    run_op(1'b1, ILw, 32'h06, 32'd0);
    check_eq("mis_lw_exc",    32'(op_exc),    32'd1);
    check_eq("mis_lw_stalls", 32'(op_stalls), 32'd0);
    check_eq("mis_lw_regwr",  32'(op_rw),     32'd0);
    check_eq("mis_lw_data",   op_rd,          32'd0);
    run_op(1'b1, ISw, Depth * 4, 32'h0000_0055);
    check_eq("oor_sw_exc",    32'(op_exc),    32'd1);
    check_eq("oor_sw_stalls", 32'(op_stalls), 32'd0);
    run_op(1'b1, ISw, 32'h12, 32'h0000_0077);
    check_eq("mis_sw_exc",    32'(op_exc),    32'd1);
    load_expect("oor_no_wrap",  ILw, 32'h00, 32'd0);
    load_expect("mis_no_write", ILw, 32'h10, 32'hDEAD_BEEF);
    run_op(1'b1, ILw, Depth * 4 - 4, 32'd0);
    check_eq("last_word_exc", 32'(op_exc), 32'd0);

    // Non-memory decode.
    run_op(1'b1, IAddi, 32'h10, 32'd0);
    check_eq("addi_regwr",  32'(op_rw),     32'd1);
    check_eq("addi_m2r",    32'(op_m2r),    32'd0);
    check_eq("addi_stalls", 32'(op_stalls), 32'd0);
    run_op(1'b1, IJal, 32'h0, 32'd0);
    check_eq("jal_regwr", 32'(op_rw),  32'd1);
    check_eq("jal_m2r",   32'(op_m2r), 32'd2);
    run_op(1'b1, IJr, 32'h0, 32'd0);
    check_eq("jr_regwr", 32'(op_rw), 32'd0);
    run_op(1'b1, IJalr, 32'h0, 32'd0);
    check_eq("jalr_regwr", 32'(op_rw),  32'd1);
    check_eq("jalr_m2r",   32'(op_m2r), 32'd2);
    run_op(1'b1, IAdd, 32'h0, 32'd0);
    check_eq("add_regwr", 32'(op_rw), 32'd1);
    run_op(1'b0, ILw, 32'h10, 32'd0);
    check_eq("inval_regwr",  32'(op_rw),     32'd0);
    check_eq("inval_m2r",    32'(op_m2r),    32'd0);
    check_eq("inval_stalls", 32'(op_stalls), 32'd0);
    check_eq("inval_data",   op_rd,          32'd0);

`ifdef MEM_SUBWORD_EN
    run_op(1'b1, ISb, 32'h33, 32'h0000_0080);
    check_eq("sb_stalls", 32'(op_stalls), 32'd2);
    load_expect("sb_word", ILw,  32'h30, 32'h8000_0000);
    load_expect("lb_sext", ILb,  32'h33, 32'hFFFF_FF80);
    load_expect("lbu_zext", ILbu, 32'h33, 32'h0000_0080);
    run_op(1'b1, ISw, 32'h38, 32'hCAFE_BABE);
    bus_if.ForwardRTM = 2'b01;
    run_op(1'b1, ISh, 32'h3A, 32'hAAAA_AAAA);
    bus_if.ForwardRTM = 2'b00;
    load_expect("sh_word",  ILw,  32'h38, 32'h5678_BABE);
    load_expect("lh_sext",  ILh,  32'h38, 32'hFFFF_BABE);
    load_expect("lhu_zext", ILhu, 32'h3A, 32'h0000_5678);
    run_op(1'b1, ILh, 32'h39, 32'd0);
    check_eq("lh_mis_exc", 32'(op_exc), 32'd1);
`else
    run_op(1'b1, ISb, 32'h4, 32'h0000_00FF);
    check_eq("sb_nop_stalls", 32'(op_stalls), 32'd0);
    check_eq("sb_nop_regwr",  32'(op_rw),     32'd0);
    check_eq("sb_nop_exc",    32'(op_exc),    32'd0);
    load_expect("sb_nop_mem", ILw, 32'h4, 32'd0);
    run_op(1'b1, ILb, 32'h4, 32'd0);
    check_eq("lb_nop_regwr",  32'(op_rw),     32'd0);
    check_eq("lb_nop_m2r",    32'(op_m2r),    32'd0);
    check_eq("lb_nop_stalls", 32'(op_stalls), 32'd0);
`endif

    // Reset during the first WAIT cycle of sw 0x40 aborts it and clears memory.
    bus_if.valid_M     = 1'b1;
    bus_if.instr_M     = ISw;
    bus_if.ALUout_M    = 32'h40;
    bus_if.WriteData_M = 32'h1;
    @(negedge clk);
    check_eq("abort_stall_pre", 32'(bus_if.stall_M), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset          = 1'b0;
    bus_if.valid_M = 1'b0;
    @(negedge clk);
    check_eq("abort_stall_post", 32'(bus_if.stall_M), 32'd0);
    @(posedge clk);
    #1;
    load_expect("abort_no_write", ILw, 32'h40, 32'd0);
    load_expect("reset_cleared",  ILw, 32'h10, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
